// File: rtl/ctrl_hazard_pipe_pkg.sv
// +------------------------------------------------------------------+
// | ctrl_hazard_pipe_pkg : shared encodings for the control pipeline  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package ctrl_hazard_pipe_pkg;

  localparam int REG_AW_DEF     = 5;
  localparam int ALU_CTRL_W_DEF = 3;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_hazard_pipe_if.sv
// +------------------------------------------------------------------+
// | ctrl_hazard_pipe_if : decode-side inputs and E/M/W/hazard outputs |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface ctrl_hazard_pipe_if #(
  parameter int REG_AW     = 5,
  parameter int ALU_CTRL_W = 3
);

  logic                  RegWriteD, MemWriteD, JumpD, jalrD, BranchD, ALUSrcD;
  logic [1:0]            ResultSrcD;
  logic [ALU_CTRL_W-1:0] ALUCtrlD;
  logic [REG_AW-1:0]     rs1D, rs2D, rdD;
  logic                  PCSrcE;

  logic                  RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
  logic [1:0]            ResultSrcE;
  logic [ALU_CTRL_W-1:0] ALUCtrlE;
  logic [REG_AW-1:0]     rs1E, rs2E, rdE;

  logic                  RegWriteM, MemWriteM;
  logic [1:0]            ResultSrcM;
  logic [REG_AW-1:0]     rdM;

  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;
  logic [REG_AW-1:0]     rdW;

  logic                  StallF, StallD, FlushD, FlushE;
  logic [1:0]            ForwardAE, ForwardBE;
  logic [31:0]           stall_cnt, flush_cnt;

  modport master (
    output RegWriteD, MemWriteD, JumpD, jalrD, BranchD, ALUSrcD,
           ResultSrcD, ALUCtrlD, rs1D, rs2D, rdD, PCSrcE,
    input  RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE,
           ResultSrcE, ALUCtrlE, rs1E, rs2E, rdE,
           RegWriteM, MemWriteM, ResultSrcM, rdM,
           RegWriteW, ResultSrcW, rdW,
           StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  RegWriteD, MemWriteD, JumpD, jalrD, BranchD, ALUSrcD,
           ResultSrcD, ALUCtrlD, rs1D, rs2D, rdD, PCSrcE,
    output RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE,
           ResultSrcE, ALUCtrlE, rs1E, rs2E, rdE,
           RegWriteM, MemWriteM, ResultSrcM, rdM,
           RegWriteW, ResultSrcW, rdW,
           StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/ctrl_hazard_pipe_hazard_unit.sv
// +------------------------------------------------------------------+
// | ctrl_hazard_pipe_hazard_unit : load-use stall, flush, forwarding  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module ctrl_hazard_pipe_hazard_unit
  import ctrl_hazard_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [1:0]        result_src_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic              pc_src_e_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_w_i,
  input  logic [REG_AW-1:0] rd_w_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o
);

  logic w_lw_stall;

  function automatic logic [1:0] fwd_sel(
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] rd_w,
    input logic [REG_AW-1:0] rs
  );
    // Youngest producer wins; x0 is hardwired and never a forwarding source.
    if (rw_m && (rd_m != '0) && (rd_m == rs))
      return FWD_MEM;
    else if (rw_w && (rd_w != '0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign w_lw_stall = (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // A taken redirect overrides the stall so the PC can load the target.
  assign stall_f_o = w_lw_stall & ~pc_src_e_i;
  assign stall_d_o = stall_f_o;
  assign flush_d_o = pc_src_e_i;
  assign flush_e_o = w_lw_stall | pc_src_e_i;

  assign forward_a_o = fwd_sel(reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i, rs1_e_i);
  assign forward_b_o = fwd_sel(reg_write_m_i, rd_m_i, reg_write_w_i, rd_w_i, rs2_e_i);

endmodule

`default_nettype wire

// File: rtl/ctrl_hazard_pipe.sv
// +------------------------------------------------------------------+
// | ctrl_hazard_pipe : control half of ID/EX, EX/MEM, MEM/WB + hazards|
// | Optional counters: CTRL_PIPE_PERF_EN. Rev 1.0                     |
// +------------------------------------------------------------------+
`default_nettype none

module ctrl_hazard_pipe
  import ctrl_hazard_pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  ctrl_hazard_pipe_if.slave    bus
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  jalr;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
  } e_stage_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } m_stage_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
  } w_stage_t;

  e_stage_t e_d, e_q;
  m_stage_t m_d, m_q;
  w_stage_t w_d, w_q;

  logic       w_stall_f, w_stall_d, w_flush_d, w_flush_e;
  logic [1:0] w_fwd_a, w_fwd_b;

  ctrl_hazard_pipe_hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard_unit (
    .result_src_e_i (e_q.result_src),
    .rd_e_i         (e_q.rd),
    .rs1_e_i        (e_q.rs1),
    .rs2_e_i        (e_q.rs2),
    .rs1_d_i        (bus.rs1D),
    .rs2_d_i        (bus.rs2D),
    .pc_src_e_i     (bus.PCSrcE),
    .reg_write_m_i  (m_q.reg_write),
    .rd_m_i         (m_q.rd),
    .reg_write_w_i  (w_q.reg_write),
    .rd_w_i         (w_q.rd),
    .stall_f_o      (w_stall_f),
    .stall_d_o      (w_stall_d),
    .flush_d_o      (w_flush_d),
    .flush_e_o      (w_flush_e),
    .forward_a_o    (w_fwd_a),
    .forward_b_o    (w_fwd_b)
  );

  // E never stalls: it either takes the decode bundle or becomes a bubble.
  always_comb begin
    e_d = '0;
    if (!w_flush_e) begin
      e_d.reg_write  = bus.RegWriteD;
      e_d.mem_write  = bus.MemWriteD;
      e_d.jump       = bus.JumpD;
      e_d.jalr       = bus.jalrD;
      e_d.branch     = bus.BranchD;
      e_d.alu_src    = bus.ALUSrcD;
      e_d.result_src = bus.ResultSrcD;
      e_d.alu_ctrl   = bus.ALUCtrlD;
      e_d.rs1        = bus.rs1D;
      e_d.rs2        = bus.rs2D;
      e_d.rd         = bus.rdD;
    end
  end

  assign m_d = '{reg_write: e_q.reg_write, mem_write: e_q.mem_write,
                 result_src: e_q.result_src, rd: e_q.rd};
  assign w_d = '{reg_write: m_q.reg_write, result_src: m_q.result_src, rd: m_q.rd};

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign bus.RegWriteE  = e_q.reg_write;
  assign bus.MemWriteE  = e_q.mem_write;
  assign bus.JumpE      = e_q.jump;
  assign bus.jalrE      = e_q.jalr;
  assign bus.BranchE    = e_q.branch;
  assign bus.ALUSrcE    = e_q.alu_src;
  assign bus.ResultSrcE = e_q.result_src;
  assign bus.ALUCtrlE   = e_q.alu_ctrl;
  assign bus.rs1E       = e_q.rs1;
  assign bus.rs2E       = e_q.rs2;
  assign bus.rdE        = e_q.rd;

  assign bus.RegWriteM  = m_q.reg_write;
  assign bus.MemWriteM  = m_q.mem_write;
  assign bus.ResultSrcM = m_q.result_src;
  assign bus.rdM        = m_q.rd;

  assign bus.RegWriteW  = w_q.reg_write;
  assign bus.ResultSrcW = w_q.result_src;
  assign bus.rdW        = w_q.rd;

  assign bus.StallF     = w_stall_f;
  assign bus.StallD     = w_stall_d;
  assign bus.FlushD     = w_flush_d;
  assign bus.FlushE     = w_flush_e;
  assign bus.ForwardAE  = w_fwd_a;
  assign bus.ForwardBE  = w_fwd_b;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall_f) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (w_flush_e) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_hazard_pipe.sv
// +------------------------------------------------------------------+
// | tb_ctrl_hazard_pipe : scoreboard bench for ctrl_hazard_pipe       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ctrl_hazard_pipe;

  typedef struct packed {
    logic       rw, mw, j, jr, br, as;
    logic [1:0] rsrc;
    logic [2:0] alu;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errs = 0;
  int   cyc = 0;
  int   exp_stalls = 0;
  int   exp_flushes = 0;
  ins_t sb[$];

  always #5 clk = ~clk;

  ctrl_hazard_pipe_if #(.REG_AW(5), .ALU_CTRL_W(3)) bus ();

  ctrl_hazard_pipe #(.REG_AW(5), .ALU_CTRL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t f_alu(input logic [4:0] rd, rs1, rs2, input logic [2:0] alu);
    ins_t i = '0;
    i.rw = 1'b1; i.alu = alu; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t f_lw(input logic [4:0] rd, rs1);
    ins_t i = '0;
    i.rw = 1'b1; i.as = 1'b1; i.rsrc = 2'b01; i.rs1 = rs1; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t f_sw(input logic [4:0] rs1, rs2);
    ins_t i = '0;
    i.mw = 1'b1; i.as = 1'b1; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic ins_t f_br(input logic [4:0] rs1, rs2);
    ins_t i = '0;
    i.br = 1'b1; i.alu = 3'b001; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic ins_t f_jal(input logic [4:0] rd);
    ins_t i = '0;
    i.rw = 1'b1; i.j = 1'b1; i.rsrc = 2'b10; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t f_jalr(input logic [4:0] rd, rs1);
    ins_t i = '0;
    i.rw = 1'b1; i.jr = 1'b1; i.as = 1'b1; i.rsrc = 2'b10; i.rs1 = rs1; i.rd = rd;
    return i;
  endfunction

  task automatic drive(input ins_t d, input logic pc);
    bus.RegWriteD  = d.rw;   bus.MemWriteD = d.mw;  bus.JumpD   = d.j;
    bus.jalrD      = d.jr;   bus.BranchD   = d.br;  bus.ALUSrcD = d.as;
    bus.ResultSrcD = d.rsrc; bus.ALUCtrlD  = d.alu;
    bus.rs1D       = d.rs1;  bus.rs2D      = d.rs2; bus.rdD     = d.rd;
    bus.PCSrcE     = pc;
  endtask

  function automatic logic [31:0] e_obs();
    return 32'({bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.jalrE, bus.BranchE,
                bus.ALUSrcE, bus.ResultSrcE, bus.ALUCtrlE, bus.rs1E, bus.rs2E, bus.rdE});
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " E"}, e_obs(), 32'd0);
    check({tag, " M"}, 32'({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.rdM}), 32'd0);
    check({tag, " W"}, 32'({bus.RegWriteW, bus.ResultSrcW, bus.rdW}), 32'd0);
    check({tag, " hazards"}, 32'({bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
                                  bus.ForwardAE, bus.ForwardBE}), 32'd0);
    check({tag, " stall_cnt"}, bus.stall_cnt, 32'd0);
    check({tag, " flush_cnt"}, bus.flush_cnt, 32'd0);
  endtask

  // One pipeline cycle: drive D, check combinational hazards and E/M/W against
  // the scoreboard, then record what E should capture at the coming edge.
  task automatic step(input ins_t d, input logic pc, input logic es, input logic ef,
                      input logic [1:0] fa, input logic [1:0] fb);
    ins_t ew, em, ee;
    drive(d, pc);
    @(negedge clk);
    check($sformatf("c%0d StallF", cyc), 32'(bus.StallF), 32'(es));
    check($sformatf("c%0d StallD", cyc), 32'(bus.StallD), 32'(es));
    check($sformatf("c%0d FlushD", cyc), 32'(bus.FlushD), 32'(pc));
    check($sformatf("c%0d FlushE", cyc), 32'(bus.FlushE), 32'(ef));
    check($sformatf("c%0d ForwardAE", cyc), 32'(bus.ForwardAE), 32'(fa));
    check($sformatf("c%0d ForwardBE", cyc), 32'(bus.ForwardBE), 32'(fb));
    ew = sb.pop_front();
    em = sb[0];
    ee = sb[1];
    check($sformatf("c%0d W", cyc), 32'({bus.RegWriteW, bus.ResultSrcW, bus.rdW}),
          32'({ew.rw, ew.rsrc, ew.rd}));
    check($sformatf("c%0d M", cyc), 32'({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.rdM}),
          32'({em.rw, em.mw, em.rsrc, em.rd}));
    check($sformatf("c%0d E", cyc), e_obs(), 32'(ee));
    check($sformatf("c%0d stall_cnt", cyc), bus.stall_cnt, PERF ? 32'(exp_stalls) : 32'd0);
    check($sformatf("c%0d flush_cnt", cyc), bus.flush_cnt, PERF ? 32'(exp_flushes) : 32'd0);
    exp_stalls  += int'(es);
    exp_flushes += int'(ef);
    sb.push_back(ef ? ins_t'('0) : d);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    drive(f_alu(5'd5, 5'd0, 5'd0, 3'b010), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset1");
    @(posedge clk); #1;
    check_all_zero("reset2");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back('0);

    step(f_alu(5'd5, 5'd1, 5'd2, 3'b010), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    // Load-use on x7, then the consumer takes the WB forward.
    step(f_lw(5'd7, 5'd5),                1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd8, 5'd7, 5'd5, 3'b000), 1'b0, 1'b1, 1'b1, 2'b10, 2'b00);
    step(f_alu(5'd8, 5'd7, 5'd5, 3'b000), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_sw(5'd0, 5'd0),                1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
    // Two writers of x3 in M and W: M wins, then W once M retires.
    step(f_alu(5'd3, 5'd1, 5'd2, 3'b011), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd3, 5'd4, 5'd4, 3'b100), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd9, 5'd3, 5'd3, 3'b101), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd10, 5'd3, 5'd3, 3'b110), 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
    step(f_jalr(5'd1, 5'd0),              1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    // x0 guard: lw to x0 never stalls, rdM=0 never forwards.
    step(f_lw(5'd0, 5'd0),                1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd11, 5'd0, 5'd0, 3'b111), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step('0,                              1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    // Redirect coinciding with a load-use stall.
    step(f_lw(5'd6, 5'd1),                1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd12, 5'd6, 5'd2, 3'b000), 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    step(f_alu(5'd13, 5'd1, 5'd2, 3'b001), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_lw(5'd14, 5'd2),               1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd15, 5'd3, 5'd14, 3'b010), 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    step(f_alu(5'd15, 5'd3, 5'd14, 3'b010), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_br(5'd15, 5'd0),               1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
    step(f_alu(5'd16, 5'd1, 5'd1, 3'b011), 1'b1, 1'b0, 1'b1, 2'b10, 2'b00);
    step(f_lw(5'd17, 5'd0),               1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_alu(5'd18, 5'd17, 5'd17, 3'b100), 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    step(f_alu(5'd18, 5'd17, 5'd17, 3'b100), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_jal(5'd2),                     1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
    for (int i = 0; i < 3; i++)
      step('0,                            1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    step(f_lw(5'd7, 5'd0),                1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    // Reset lands while a load-use stall is active.
    drive(f_alu(5'd19, 5'd7, 5'd0, 3'b000), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst StallF before", 32'(bus.StallF), 32'd1);
    check("midrst FlushE before", 32'(bus.FlushE), 32'd1);
    @(posedge clk); #1;
    check_all_zero("midrst");
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_hazard_pipe.md
Name: ctrl_hazard_pipe

Overview:
- Downstream consumer of the main decoder's outputs.
- Registers decode-stage control bits and register addresses through the Execute, Memory and Writeback stages of the 5-stage RISC-V pipeline.
- Generates the load-use stall, control-flow flush and operand-forwarding selects the datapath needs.
- Sits between the decode-stage control logic and the datapath pipeline registers. It owns the control half of the ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
- REG_AW, 5, register-address width.
- ALU_CTRL_W, 3, width of the ALU control field carried D->E.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; clears all stage registers to bubble
- RegWriteD, MemWriteD, JumpD, jalrD, BranchD, ALUSrcD  in  1 each  decode-stage controls
- ResultSrcD  in  2  result mux select (01 = load)
- ALUCtrlD  in  ALU_CTRL_W  decode-stage ALU control
- rs1D, rs2D, rdD  in  REG_AW each  decode-stage register addresses
- PCSrcE  in  1  taken branch or jump resolved in Execute
- RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE  out  1 each  Execute-stage controls
- ResultSrcE  out  2  Execute-stage result select
- ALUCtrlE  out  ALU_CTRL_W  Execute-stage ALU control
- rs1E, rs2E, rdE  out  REG_AW each  Execute-stage register addresses
- RegWriteM, MemWriteM  out  1 each  Memory-stage controls
- ResultSrcM  out  2  Memory-stage result select
- rdM  out  REG_AW  Memory-stage destination
- RegWriteW  out  1  Writeback-stage write enable
- ResultSrcW  out  2  Writeback-stage result select
- rdW  out  REG_AW  Writeback-stage destination
- StallF, StallD, FlushD, FlushE  out  1 each  hazard controls
- ForwardAE, ForwardBE  out  2 each  ALU operand forwarding selects
- stall_cnt, flush_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- One clock (clk). Reset is synchronous, active-high (reset). While reset is high at a rising edge, every E/M/W register loads 0, so all registered outputs are 0 the following cycle.
- Latency: D->E, E->M and M->W are 1 cycle each. The M and W registers always advance; they are never stalled or flushed except by reset.
- lwStall = (ResultSrcE == 01) & (rdE != 0) & ((rdE == rs1D) | (rdE == rs2D)). Combinational.
- StallF = lwStall & ~PCSrcE. StallD = StallF. When a taken redirect coincides with a stall, the PC must load the target, so the redirect wins.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE. On a clock edge with FlushE=1, all E registers load 0 (bubble), including rs1E, rs2E and rdE.
- The E register has no stall. It either captures the D inputs or flushes.
- ForwardAE = 10 if RegWriteM & (rdM != 0) & (rdM == rs1E). Otherwise 01 if RegWriteW & (rdW != 0) & (rdW == rs1E). Otherwise 00.
  - M has priority over W.
  - ForwardBE uses the same rule with rs2E.
- Register x0 is never forwarded and never causes a stall.
- Decoder X outputs (unknown opcode) are passed through unchanged. Bubbles are clean zeros.
- Reset asserted mid-stall: all stage registers clear, and with them lwStall and the forward selects deassert the next cycle.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- Defined: stall_cnt increments on every non-reset edge where StallF=1; flush_cnt increments on every non-reset edge where FlushE=1. Both are cleared by reset and wrap modulo 2^32.
- Undefined: both ports are present and tied to constant 0; no counter flops are inferred.

Decomposition:
- Shared package holds:
  - ResultSrc encodings: RES_ALU=00, RES_MEM=01, RES_PC4=10, RES_IMM=11.
  - Forward encodings: FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - REG_AW default.
- One sub-module is natural: hazard_unit. It contains purely combinational lwStall/stall/flush/forward logic and is instantiated once. ctrl_hazard_pipe owns the stage registers.

Test Plan:
- Reset: hold reset 2 cycles with RegWriteD=1, rdD=5 -> all E/M/W outputs 0. rdD reaches rdE one cycle after reset drops, then rdM, then rdW on successive cycles.
- Load-use: cycle n lw with rdD=7; cycle n+1 add with rs1D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. rdE=0 and RegWriteE=0 the next cycle. Add enters E one cycle later with ForwardAE=01.
- Forwarding priority: add x3 in M and add x3 in W (both RegWrite=1), consumer rs1E=rs2E=3 -> ForwardAE=ForwardBE=10. Retire the M instruction -> 01.
- x0 guard: lw with rdD=0 followed by rs1D=0 -> no stall. RegWriteM=1 with rdM=0 and rs1E=0 -> ForwardAE=00.
- Redirect during stall: lwStall=1 and PCSrcE=1 in the same cycle -> StallF=0, FlushD=1, FlushE=1. The E stage holds a bubble next cycle.
- CTRL_PIPE_PERF_EN: 3 load-use stalls and 2 taken branches -> stall_cnt=3, flush_cnt=5. Reset -> both 0. Without the macro, both read 0 throughout.
